// File: rtl/rob_param.sv
// Parametrised in-order re-order buffer: DEPTH-entry circular queue with NUM_WB
// writeback channels, forwarding lookup, gated store retirement and mispredict flush.
module rob_param #(
  parameter int DEPTH        = 16,
  parameter int NUM_WB       = 2,
  parameter int FULL_WARNING = 2,
  parameter int IDW          = $clog2(DEPTH) + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  alloc_valid,
  output logic [IDW-1:0]        alloc_id,
  input  logic [4:0]            alloc_rd,
  input  logic                  alloc_is_jump,
  input  logic                  alloc_is_store,
  input  logic                  alloc_pred_jump,
  input  logic [31:0]           alloc_pc,
  input  logic [31:0]           alloc_rollback_pc,
  input  logic [IDW-1:0]        q1_id,
  input  logic [IDW-1:0]        q2_id,
  output logic                  q1_ready,
  output logic                  q2_ready,
  output logic [31:0]           q1_data,
  output logic [31:0]           q2_data,
  input  logic [NUM_WB-1:0]     wb_valid,
  input  logic [NUM_WB*IDW-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]  wb_data,
  input  logic [NUM_WB-1:0]     wb_jump,
  input  logic [NUM_WB*32-1:0]  wb_target_pc,
  input  logic                  store_go,
  output logic [IDW-1:0]        head_id,
  output logic                  commit_valid,
  output logic [IDW-1:0]        commit_id,
  output logic [4:0]            commit_rd,
  output logic [31:0]           commit_data,
  output logic                  commit_is_store,
  output logic                  pred_valid,
  output logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic                  rollback_flag,
  output logic [31:0]           rollback_pc,
  output logic [IDW-1:0]        count,
  output logic                  full,
  output logic                  almost_full
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]        r_busy, r_ready, r_is_jump, r_is_store, r_pred_jump, r_jump_taken;
  logic [DEPTH-1:0][4:0]   r_rd;
  logic [DEPTH-1:0][31:0]  r_pc, r_data, r_target, r_rb_pc;
  logic [PW-1:0]           r_head, r_tail;
  logic [IDW-1:0]          r_count;

  logic                    w_full, w_alloc_ok, w_retire, w_mispredict;
  logic [NUM_WB-1:0]       w_wb_hit;
  logic [NUM_WB-1:0][PW-1:0] w_wb_idx;
  logic [32:0]             w_q1, w_q2;

  assign w_full       = (r_count == IDW'(DEPTH));
  assign w_alloc_ok   = alloc_valid && !w_full;
  assign w_retire     = r_busy[r_head] && (r_ready[r_head] || (r_is_store[r_head] && store_go));
  assign w_mispredict = r_jump_taken[r_head] != r_pred_jump[r_head];

  assign alloc_id    = IDW'(r_tail) + IDW'(1);
  assign head_id     = r_busy[r_head] ? IDW'(r_head) + IDW'(1) : '0;
  assign count       = r_count;
  assign full        = w_full;
  assign almost_full = (r_count >= IDW'(DEPTH - FULL_WARNING));

  // Ids beyond DEPTH never name an entry, so writes to them are dropped like id 0.
  always_comb begin
    w_wb_hit = '0;
    w_wb_idx = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      w_wb_idx[k] = PW'(wb_rob_id[k*IDW +: IDW] - IDW'(1));
      w_wb_hit[k] = wb_valid[k] && (wb_rob_id[k*IDW +: IDW] != '0) &&
                    (wb_rob_id[k*IDW +: IDW] <= IDW'(DEPTH)) &&
                    r_busy[PW'(wb_rob_id[k*IDW +: IDW] - IDW'(1))];
    end
  end

  function automatic logic [32:0] f_lookup(input logic [IDW-1:0] id);
    logic [32:0] v_res;
    v_res = '0;
    if (id != '0) begin
      if (id <= IDW'(DEPTH))
        v_res = {r_ready[PW'(id - IDW'(1))], r_data[PW'(id - IDW'(1))]};
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && (wb_rob_id[k*IDW +: IDW] == id))
          v_res = {1'b1, wb_data[k*32 +: 32]};
    end
    return v_res;
  endfunction

  always_comb begin
    w_q1 = f_lookup(q1_id);
    w_q2 = f_lookup(q2_id);
  end

  assign q1_ready = w_q1[32];
  assign q1_data  = w_q1[31:0];
  assign q2_ready = w_q2[32];
  assign q2_data  = w_q2[31:0];

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && rollback_flag)) begin
      r_busy          <= '0;
      r_ready         <= '0;
      r_is_jump       <= '0;
      r_is_store      <= '0;
      r_pred_jump     <= '0;
      r_jump_taken    <= '0;
      r_rd            <= '0;
      r_pc            <= '0;
      r_data          <= '0;
      r_target        <= '0;
      r_rb_pc         <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      commit_valid    <= 1'b0;
      commit_id       <= '0;
      commit_rd       <= '0;
      commit_data     <= '0;
      commit_is_store <= 1'b0;
      pred_valid      <= 1'b0;
      pred_pc         <= '0;
      pred_taken      <= 1'b0;
      rollback_flag   <= 1'b0;
      rollback_pc     <= '0;
    end else if (rdy_in) begin
      commit_valid  <= 1'b0;
      pred_valid    <= 1'b0;
      rollback_flag <= 1'b0;

      if (w_alloc_ok) begin
        r_busy[r_tail]       <= 1'b1;
        r_ready[r_tail]      <= 1'b0;
        r_is_jump[r_tail]    <= alloc_is_jump;
        r_is_store[r_tail]   <= alloc_is_store;
        r_pred_jump[r_tail]  <= alloc_pred_jump;
        r_jump_taken[r_tail] <= 1'b0;
        r_rd[r_tail]         <= alloc_rd;
        r_pc[r_tail]         <= alloc_pc;
        r_data[r_tail]       <= '0;
        r_target[r_tail]     <= '0;
        r_rb_pc[r_tail]      <= alloc_rollback_pc;
        r_tail               <= r_tail + PW'(1);
      end

      // Later channels overwrite earlier ones on an id collision.
      for (int k = 0; k < NUM_WB; k++) begin
        if (w_wb_hit[k]) begin
          r_ready[w_wb_idx[k]]      <= 1'b1;
          r_data[w_wb_idx[k]]       <= wb_data[k*32 +: 32];
          r_target[w_wb_idx[k]]     <= wb_target_pc[k*32 +: 32];
          r_jump_taken[w_wb_idx[k]] <= wb_jump[k];
        end
      end

      if (w_retire) begin
        commit_valid    <= 1'b1;
        commit_id       <= IDW'(r_head) + IDW'(1);
        commit_rd       <= r_rd[r_head];
        commit_data     <= r_data[r_head];
        commit_is_store <= r_is_store[r_head];
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
        if (r_is_jump[r_head]) begin
          pred_valid <= 1'b1;
          pred_pc    <= r_pc[r_head];
          pred_taken <= r_jump_taken[r_head];
          if (w_mispredict) begin
            rollback_flag <= 1'b1;
            rollback_pc   <= r_jump_taken[r_head] ? r_target[r_head] : r_rb_pc[r_head];
          end
        end
      end

      case ({w_alloc_ok, w_retire})
        2'b10:   r_count <= r_count + IDW'(1);
        2'b01:   r_count <= r_count - IDW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: lookup vector table plus commit scoreboard
// fed at allocation time and drained by a commit monitor.
module tb_rob_param;
  localparam int DEPTH  = 16;
  localparam int NUM_WB = 2;
  localparam int IDW    = 5;

  logic              clk_in, rst_in, rdy_in;
  logic              alloc_valid;
  logic [IDW-1:0]    alloc_id;
  logic [4:0]        alloc_rd;
  logic              alloc_is_jump, alloc_is_store, alloc_pred_jump;
  logic [31:0]       alloc_pc, alloc_rollback_pc;
  logic [IDW-1:0]    q1_id, q2_id;
  logic              q1_ready, q2_ready;
  logic [31:0]       q1_data, q2_data;
  logic [NUM_WB-1:0] wb_valid, wb_jump;
  logic [NUM_WB*IDW-1:0] wb_rob_id;
  logic [NUM_WB*32-1:0]  wb_data, wb_target_pc;
  logic              store_go;
  logic [IDW-1:0]    head_id, commit_id, count;
  logic              commit_valid, commit_is_store;
  logic [4:0]        commit_rd;
  logic [31:0]       commit_data, pred_pc, rollback_pc;
  logic              pred_valid, pred_taken, rollback_flag, full, almost_full;

  rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .FULL_WARNING(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_rd(alloc_rd),
    .alloc_is_jump(alloc_is_jump), .alloc_is_store(alloc_is_store),
    .alloc_pred_jump(alloc_pred_jump), .alloc_pc(alloc_pc),
    .alloc_rollback_pc(alloc_rollback_pc),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .wb_jump(wb_jump), .wb_target_pc(wb_target_pc),
    .store_go(store_go), .head_id(head_id),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_is_store(commit_is_store),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .rollback_flag(rollback_flag), .rollback_pc(rollback_pc),
    .count(count), .full(full), .almost_full(almost_full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: ids pushed at allocation, data tracked by a writeback model.
  logic [IDW-1:0] exp_q[$];
  logic [4:0]     exp_rd   [32];
  logic [31:0]    exp_data [32];
  logic           exp_store[32];
  logic           exp_busy [32];
  logic [IDW-1:0] tb_next;
  logic [IDW-1:0] m_id;
  logic           last_rdy;

  always @(posedge clk_in) last_rdy <= rdy_in;

  always @(negedge clk_in) begin
    if (commit_valid && last_rdy) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: got id %0d expected none", commit_id);
      end else begin
        m_id = exp_q.pop_front();
        check("sb_commit_id",    64'(commit_id),       64'(m_id));
        check("sb_commit_rd",    64'(commit_rd),       64'(exp_rd[m_id]));
        check("sb_commit_data",  64'(commit_data),     64'(exp_data[m_id]));
        check("sb_commit_store", 64'(commit_is_store), 64'(exp_store[m_id]));
        exp_busy[m_id] = 1'b0;
      end
    end
  end

  task automatic clk1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_flush();
    exp_q.delete();
    tb_next = 5'd1;
    for (int i = 0; i < 32; i++) exp_busy[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    clk1();
    rst_in = 1'b0;
    model_flush();
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st, input logic jmp,
                       input logic pj, input logic [31:0] pc, input logic [31:0] rbpc);
    alloc_valid = 1'b1; alloc_rd = rd; alloc_is_store = st; alloc_is_jump = jmp;
    alloc_pred_jump = pj; alloc_pc = pc; alloc_rollback_pc = rbpc;
    clk1();
    alloc_valid = 1'b0;
    exp_q.push_back(tb_next);
    exp_rd[tb_next] = rd; exp_data[tb_next] = 32'h0;
    exp_store[tb_next] = st; exp_busy[tb_next] = 1'b1;
    tb_next = (tb_next == 5'd16) ? 5'd1 : tb_next + 5'd1;
  endtask

  task automatic set_wb(input int ch, input logic [4:0] id, input logic [31:0] d,
                        input logic j, input logic [31:0] tpc);
    wb_valid[ch] = 1'b1;
    wb_rob_id[ch*IDW +: IDW] = id;
    wb_data[ch*32 +: 32] = d;
    wb_jump[ch] = j;
    wb_target_pc[ch*32 +: 32] = tpc;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_rob_id = '0; wb_data = '0; wb_jump = '0; wb_target_pc = '0;
  endtask

  task automatic model_wb();
    logic [4:0] id;
    for (int k = 0; k < NUM_WB; k++) begin
      id = wb_rob_id[k*IDW +: IDW];
      if (wb_valid[k] && id != 5'd0 && exp_busy[id]) exp_data[id] = wb_data[k*32 +: 32];
    end
  endtask

  task automatic step_wb();
    model_wb();
    clk1();
    clear_wb();
  endtask

  typedef struct {
    logic        v0; logic [4:0] id0; logic [31:0] d0;
    logic        v1; logic [4:0] id1; logic [31:0] d1;
    logic [4:0]  q;  logic exp_rdy;   logic [31:0] exp_d;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd2, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'h0,  5'd2, 1'b1, 32'hA2};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd2, 1'b1, 32'hA2};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'hB3, 5'd3, 1'b1, 32'hB3};
    tbl[4]  = '{1'b1, 5'd4, 32'hC4, 1'b1, 5'd4, 32'hD4, 5'd4, 1'b1, 32'hD4};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 1'b1, 32'hD4};
    tbl[6]  = '{1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h77, 5'd7, 1'b1, 32'h77};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 5'd3, 32'h99, 1'b0, 5'd0, 32'h0,  5'd3, 1'b1, 32'h99};
    tbl[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 1'b1, 32'h99};

    rst_in = 1'b1; rdy_in = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    alloc_is_jump = 1'b0; alloc_is_store = 1'b0; alloc_pred_jump = 1'b0;
    alloc_pc = '0; alloc_rollback_pc = '0; q1_id = '0; q2_id = '0; store_go = 1'b0;
    clear_wb();
    do_reset();

    check("rst_alloc_id",     64'(alloc_id),      64'd1);
    check("rst_count",        64'(count),         64'd0);
    check("rst_full",         64'(full),          64'd0);
    check("rst_almost_full",  64'(almost_full),   64'd0);
    check("rst_head_id",      64'(head_id),       64'd0);
    check("rst_commit_valid", 64'(commit_valid),  64'd0);
    check("rst_pred_valid",   64'(pred_valid),    64'd0);
    check("rst_rollback",     64'(rollback_flag), 64'd0);
    check("rst_q1_ready",     64'(q1_ready),      64'd0);

    // Fill to capacity, then the overflow attempt is ignored.
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_alloc_id", 64'(alloc_id), 64'(i + 1));
      alloc(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'(i * 4), 32'h0);
      check("fill_almost_full", 64'(almost_full), 64'((i + 1) >= DEPTH - 2));
    end
    check("full_count", 64'(count), 64'd16);
    check("full_flag",  64'(full),  64'd1);
    alloc_valid = 1'b1; alloc_rd = 5'd31;
    clk1();
    alloc_valid = 1'b0;
    check("ovf_count",    64'(count),    64'd16);
    check("ovf_alloc_id", 64'(alloc_id), 64'd1);
    check("ovf_head_id",  64'(head_id),  64'd1);

    // Same-id dual writeback: channel 1 wins, both forwarded and stored.
    set_wb(0, 5'd3, 32'h55, 1'b0, 32'h0);
    set_wb(1, 5'd3, 32'h77, 1'b0, 32'h0);
    q1_id = 5'd3; q2_id = 5'd5;
    @(negedge clk_in);
    check("fwd_q1_ready", 64'(q1_ready), 64'd1);
    check("fwd_q1_data",  64'(q1_data),  64'h77);
    check("fwd_q2_ready", 64'(q2_ready), 64'd0);
    check("fwd_q2_data",  64'(q2_data),  64'h0);
    step_wb();
    check("stored_q1_ready", 64'(q1_ready), 64'd1);
    check("stored_q1_data",  64'(q1_data),  64'h77);

    set_wb(0, 5'd1, 32'h11, 1'b0, 32'h0);
    step_wb();
    alloc_valid = 1'b1; alloc_rd = 5'd31;
    clk1();
    alloc_valid = 1'b0;
    check("r1_commit_valid", 64'(commit_valid), 64'd1);
    check("r1_commit_id",    64'(commit_id),    64'd1);
    check("r1_count",        64'(count),        64'd15);
    check("r1_full",         64'(full),         64'd0);
    alloc(5'd20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("refill_full", 64'(full), 64'd1);
    set_wb(0, 5'd2, 32'h22, 1'b0, 32'h0);
    step_wb();
    check("ord_wait_valid", 64'(commit_valid), 64'd0);
    clk1();
    check("ord_c2_id", 64'(commit_id), 64'd2);
    clk1();
    check("ord_c3_valid", 64'(commit_valid), 64'd1);
    check("ord_c3_id",    64'(commit_id),    64'd3);
    check("ord_c3_data",  64'(commit_data),  64'h77);
    clk1();
    check("ord_idle_valid", 64'(commit_valid), 64'd0);
    check("ord_count",      64'(count),        64'd14);

    // Lookup vector table over ids 2..4 with id 1 held not ready.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      clear_wb();
      if (tbl[i].v0) set_wb(0, tbl[i].id0, tbl[i].d0, 1'b0, 32'h0);
      if (tbl[i].v1) set_wb(1, tbl[i].id1, tbl[i].d1, 1'b0, 32'h0);
      q1_id = tbl[i].q; q2_id = tbl[i].q;
      @(negedge clk_in);
      check("tbl_q1_ready", 64'(q1_ready), 64'(tbl[i].exp_rdy));
      check("tbl_q1_data",  64'(q1_data),  64'(tbl[i].exp_d));
      check("tbl_q2_ready", 64'(q2_ready), 64'(tbl[i].exp_rdy));
      check("tbl_q2_data",  64'(q2_data),  64'(tbl[i].exp_d));
      step_wb();
    end
    set_wb(0, 5'd1, 32'h11, 1'b0, 32'h0);
    step_wb();
    for (int c = 0; c < 10 && count != 5'd0; c++) clk1();
    clk1();
    check("tbl_drain_count", 64'(count),        64'd0);
    check("tbl_drain_sb",    64'(exp_q.size()), 64'd0);

    // Store at head waits for store_go.
    do_reset();
    alloc(5'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    alloc(5'd6, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 5; i++) begin
      clk1();
      check("st_hold_valid", 64'(commit_valid), 64'd0);
    end
    store_go = 1'b1;
    clk1();
    store_go = 1'b0;
    check("st_commit_valid", 64'(commit_valid),    64'd1);
    check("st_commit_store", 64'(commit_is_store), 64'd1);
    set_wb(0, 5'd2, 32'h66, 1'b0, 32'h0);
    step_wb();
    clk1();
    check("st_next_id",    64'(commit_id),       64'd2);
    check("st_next_store", 64'(commit_is_store), 64'd0);
    clk1();

    // Taken mispredict at head flushes three ready younger entries.
    do_reset();
    alloc(5'd1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h404);
    for (int i = 0; i < 3; i++) alloc(5'(i + 2), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_wb(0, 5'd1, 32'h404, 1'b1, 32'h1000);
    set_wb(1, 5'd2, 32'h2, 1'b0, 32'h0);
    step_wb();
    set_wb(0, 5'd3, 32'h3, 1'b0, 32'h0);
    set_wb(1, 5'd4, 32'h4, 1'b0, 32'h0);
    step_wb();
    check("mp_commit_id",  64'(commit_id),     64'd1);
    check("mp_pred_valid", 64'(pred_valid),    64'd1);
    check("mp_pred_taken", 64'(pred_taken),    64'd1);
    check("mp_pred_pc",    64'(pred_pc),       64'h400);
    check("mp_rollback",   64'(rollback_flag), 64'd1);
    check("mp_rb_pc",      64'(rollback_pc),   64'h1000);
    check("mp_count",      64'(count),         64'd3);
    @(negedge clk_in);
    #1;
    exp_q.delete();
    clk1();
    check("fl_rollback", 64'(rollback_flag), 64'd0);
    check("fl_commit",   64'(commit_valid),  64'd0);
    check("fl_count",    64'(count),         64'd0);
    check("fl_head_id",  64'(head_id),       64'd0);
    check("fl_alloc_id", 64'(alloc_id),      64'd1);
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("fl_quiet", 64'(commit_valid), 64'd0);
    end
    model_flush();

    // Correct prediction, then not-taken mispredict back to rollback_pc.
    alloc(5'd7, 1'b0, 1'b1, 1'b1, 32'h800, 32'h804);
    alloc(5'd8, 1'b0, 1'b1, 1'b1, 32'h900, 32'h904);
    set_wb(0, 5'd1, 32'h0, 1'b1, 32'h2000);
    set_wb(1, 5'd2, 32'h0, 1'b0, 32'h5555);
    step_wb();
    clk1();
    check("ok_pred_valid", 64'(pred_valid),    64'd1);
    check("ok_pred_taken", 64'(pred_taken),    64'd1);
    check("ok_pred_pc",    64'(pred_pc),       64'h800);
    check("ok_rollback",   64'(rollback_flag), 64'd0);
    clk1();
    check("nt_pred_taken", 64'(pred_taken),    64'd0);
    check("nt_pred_pc",    64'(pred_pc),       64'h900);
    check("nt_rollback",   64'(rollback_flag), 64'd1);
    check("nt_rb_pc",      64'(rollback_pc),   64'h904);
    clk1();
    check("nt_flush_rb",    64'(rollback_flag), 64'd0);
    check("nt_flush_count", 64'(count),         64'd0);
    model_flush();

    // rdy_in low freezes state and pulses; an alloc offered then is not taken.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 9), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_wb(0, 5'd1, 32'h31, 1'b0, 32'h0);
    set_wb(1, 5'd2, 32'h32, 1'b0, 32'h0);
    step_wb();
    set_wb(0, 5'd3, 32'h33, 1'b0, 32'h0);
    step_wb();
    check("rdy_pre_id", 64'(commit_id), 64'd1);
    rdy_in = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd30;
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("frz_commit_valid", 64'(commit_valid), 64'd1);
      check("frz_commit_id",    64'(commit_id),    64'd1);
      check("frz_head_id",      64'(head_id),      64'd2);
      check("frz_count",        64'(count),        64'd2);
      check("frz_alloc_id",     64'(alloc_id),     64'd4);
    end
    alloc_valid = 1'b0;
    rdy_in = 1'b1;
    clk1();
    check("res_c2_id", 64'(commit_id), 64'd2);
    clk1();
    check("res_c3_id", 64'(commit_id), 64'd3);
    clk1();
    check("res_idle",  64'(commit_valid), 64'd0);
    check("res_count", 64'(count),        64'd0);
    check("res_sb",    64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
